// File: rtl/alu_seq.sv
// alu_seq: sequences a 2N-bit ADD/ADC/SUB/CMP through an external N-bit ALU
// slice, low byte first. Subtraction resolves the low-byte borrow in a
// separate FIX pass so the external ALU never needs a borrow-in on SUB.
module alu_seq #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [2*N-1:0] a,
   input  logic [2*N-1:0] b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] result,
   output logic           flag_c,
   output logic           flag_z,
   output logic [3:0]     alu_mode,
   output logic           alu_cin,
   output logic [N-1:0]   alu_a,
   output logic [N-1:0]   alu_b,
   input  logic [N-1:0]   alu_out,
   input  logic           alu_cout
);

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_ADC = 2'b01;
   localparam logic [1:0] OP_CMP = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_FIX,
      S_DONE
   } state_t;

   state_t         state;
   logic [1:0]     op_r;
   logic [2*N-1:0] a_r;
   logic [2*N-1:0] b_r;
   logic [N-1:0]   res_lo;
   logic [N-1:0]   res_hi;
   logic           c_lo;
   logic           c_hi;

   logic           is_sub;
   logic           finish;
   logic           fin_c;
   logic [2*N-1:0] fin_res;

   // op[1] selects the subtract family (SUB and CMP)
   assign is_sub = op_r[1];

   // Final values are formed from the ALU output of the last arithmetic pass
   always_comb begin
      finish  = ((state == S_HI) && !is_sub) || (state == S_FIX);
      fin_c   = (state == S_FIX) ? (c_hi | alu_cout) : alu_cout;
      fin_res = {alu_out, res_lo};
   end

   // External ALU drive, decoded from the current state; idle drive is all-zero ADD
   always_comb begin
      alu_mode = ALU_ADD;
      alu_cin  = 1'b0;
      alu_a    = '0;
      alu_b    = '0;
      case (state)
         S_LO: begin
            alu_a = a_r[N-1:0];
            alu_b = b_r[N-1:0];
            if (is_sub) alu_mode = ALU_SUB;
            else        alu_cin  = (op_r == OP_ADC) ? flag_c : 1'b0;
         end
         S_HI: begin
            alu_a = a_r[2*N-1:N];
            alu_b = b_r[2*N-1:N];
            if (is_sub) alu_mode = ALU_SUB;
            else        alu_cin  = c_lo;
         end
         S_FIX: begin
            alu_mode = ALU_SUB;
            alu_a    = res_hi;
            alu_b    = {{(N-1){1'b0}}, c_lo};
         end
         default: ;
      endcase
   end

   // Sequencer: operand capture, per-byte result capture and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         op_r   <= OP_ADD;
         a_r    <= '0;
         b_r    <= '0;
         res_lo <= '0;
         res_hi <= '0;
         c_lo   <= 1'b0;
         c_hi   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         flag_c <= 1'b0;
         flag_z <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_r  <= op;
                  a_r   <= a;
                  b_r   <= b;
                  busy  <= 1'b1;
                  state <= S_LO;
               end
            end
            S_LO: begin
               res_lo <= alu_out;
               c_lo   <= alu_cout;
               state  <= S_HI;
            end
            S_HI: begin
               res_hi <= alu_out;
               c_hi   <= alu_cout;
               state  <= is_sub ? S_FIX : S_DONE;
            end
            S_FIX: begin
               res_hi <= alu_out;
               c_hi   <= c_hi | alu_cout;
               state  <= S_DONE;
            end
            S_DONE: begin
               // first DONE cycle settles the outputs, second one carries the pulse
               if (!done) begin
                  done <= 1'b1;
               end else begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (finish) begin
            flag_c <= fin_c;
            flag_z <= (fin_res == '0);
            if (op_r != OP_CMP) result <= fin_res;
         end
      end
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the width of the external ALU slice; operand and result width SHALL be 2*N.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin an operation, sampled in IDLE only.
REQ-005 The block SHALL have port op, input, 2, the operation select: 00 ADD, 01 ADC (add with flag_c), 10 SUB, 11 CMP (SUB that updates flags only).
REQ-006 The block SHALL have ports a and b, input, 2N, the operands, captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1, high from the accepting edge until the DONE state is left.
REQ-008 The block SHALL have port done, output, 1, a single-cycle completion pulse.
REQ-009 The block SHALL have port result, output, 2N, the registered result.
REQ-010 The block SHALL have ports flag_c and flag_z, output, 1 each, the registered carry/borrow flag and zero flag.
REQ-011 The block SHALL have ports alu_mode (output, 4), alu_cin (output, 1), alu_a (output, N) and alu_b (output, N), which drive the external ALU; alu_mode SHALL use the shared ALU_ADD/ALU_SUB codes.
REQ-012 The block SHALL have ports alu_out (input, N) and alu_cout (input, 1), the external ALU result; on SUB, alu_cout=1 means borrow.

Function
REQ-013 The FSM SHALL have the states IDLE, LO, HI, FIX and DONE.
REQ-014 In IDLE with start=1, the block SHALL capture a, b and op and go to LO; when start=0 it SHALL stay in IDLE.
REQ-015 LO SHALL drive the low bytes on alu_a/alu_b.
- ADD/ADC: mode ALU_ADD; alu_cin=0 for ADD, flag_c for ADC.
- SUB/CMP: mode ALU_SUB.
- At the end of LO, the block SHALL capture alu_out into res_lo and alu_cout into c_lo.
REQ-016 HI SHALL drive the high bytes.
- ADD/ADC: ALU_ADD with alu_cin=c_lo; capture res_hi and c_hi; next state DONE.
- SUB/CMP: ALU_SUB; capture res_hi and b_hi (borrow); next state FIX.
REQ-017 FIX SHALL drive ALU_SUB with alu_a=res_hi and alu_b={N-1 zeros, c_lo}, then overwrite res_hi with alu_out.
- Final borrow = b_hi OR alu_cout.
- Next state DONE.
REQ-018 On entry to DONE, the block SHALL update the outputs:
- flag_c = final carry (ADD/ADC) or final borrow (SUB/CMP).
- flag_z = 1 if and only if {res_hi,res_lo} == 0.
- result = {res_hi,res_lo}, except that result is unchanged for CMP.
REQ-019 In DONE, the block SHALL assert done for exactly one cycle with busy=1, then return to IDLE.
REQ-020 Latency, counted from the accepting edge (edge 0), SHALL be: done high during the cycle after edge 3 for ADD/ADC and after edge 4 for SUB/CMP.
REQ-021 In IDLE, start SHALL be accepted on the edge after done falls, i.e. back-to-back operations are allowed.
REQ-022 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-023 In IDLE and DONE, the ALU drive SHALL be alu_mode=ALU_ADD, alu_cin=0 and alu_a=alu_b=0.
REQ-024 Arithmetic SHALL be modulo 2^(2N); overflow is reported only through flag_c.
REQ-025 result, flag_c and flag_z SHALL hold their values between operations; op and a/b changes while busy SHALL have no effect.

Reset
REQ-026 When reset_n=0, the block SHALL immediately, and asynchronously, force:
- state IDLE.
- busy=0, done=0, result=0, flag_c=0, flag_z=0.
- Internal byte registers 0.
- The idle ALU drive of REQ-023.
REQ-027 A reset asserted mid-operation SHALL abort the operation with no done pulse; after release, the first start SHALL behave as from power-up.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- ADD 0x00FF+0x0001 -> result 0x0100, C=0, Z=0, done in the cycle after edge 3.
- With flag_c=1 from a prior op, ADC 0xFFFF+0x0000 -> result 0x0000, C=1, Z=1.
- SUB 0x0100-0x0001 -> result 0x00FF, C=0 (borrow resolved in FIX), done in the cycle after edge 4.
- SUB 0x0000-0x0001 -> result 0xFFFF, C=1, Z=0.
- After a prior result 0xABCD, CMP 0x1234,0x1234 -> Z=1, C=0, result stays 0xABCD.
- Pulse start during HI -> ignored.
- reset_n low during FIX -> all outputs 0 immediately, no done; then ADD 1+1 -> 0x0002.
